fifo_write_arbiter: RTL

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_arb_pkg.sv | 12 +
 rtl/rr_priority_pick.sv | 34 +++
 rtl/fifo_write_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encoding and counter widths for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int BEAT_W = 4;
  localparam int STAT_W = 16;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - rotating-priority pick: first requester at or after rr_ptr, wrapping
module rr_priority_pick #(
  parameter int NREQ = 4,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] rr_ptr,
  output logic [NREQ-1:0] pick,
  output logic [IDXW-1:0] index,
  output logic            valid
);

  int               j;
  logic [IDXW-1:0]  jx;

  always_comb begin
    pick  = '0;
    index = '0;
    valid = 1'b0;
    j     = 0;
    jx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jx = IDXW'(j);
      if (!valid && req[jx]) begin
        valid    = 1'b1;
        index    = jx;
        pick[jx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - burst-limited round-robin arbiter in front of one FIFO write port
// Optional per-requester beat counters on grant_cnt when FIFO_ARB_STATS_EN is defined.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DATASIZE = 8,
  parameter int MAXBURST = 4,
  localparam int IDXW    = $clog2(NREQ)
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  input  logic                     wfull,
  output logic [NREQ-1:0]          gnt,
  output logic                     winc,
  output logic [DATASIZE-1:0]      wdata,
  output logic [IDXW-1:0]          owner,
  output logic                     busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NREQ*STAT_W-1:0]   grant_cnt
`endif
);

  arb_state_e         state_q, state_d;
  logic [IDXW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]    owner_q, owner_d;
  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic [IDXW-1:0]    owner_nxt;
  logic [IDXW-1:0]    pick_ptr;
  logic [NREQ-1:0]    pick;
  logic [IDXW-1:0]    pick_idx;
  logic               pick_valid;
  logic [NREQ-1:0]    gnt_c;
  logic [DATASIZE-1:0] wdata_c;

  assign owner_nxt = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + IDXW'(1);
  // A releasing owner arbitrates from owner+1, so it lands last in the rotation.
  assign pick_ptr  = (state_q == BURST) ? owner_nxt : rr_ptr_q;

  rr_priority_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .rr_ptr (pick_ptr),
    .pick   (pick),
    .index  (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    gnt_c      = '0;
    case (state_q)
      IDLE: begin
        if (!wfull && pick_valid) begin
          gnt_c      = pick;
          owner_d    = pick_idx;
          beat_cnt_d = BEAT_W'(1);
          state_d    = BURST;
        end
      end
      default: begin
        if (wfull) begin
          gnt_c = '0;
        end else if (req[owner_q] && (beat_cnt_q < BEAT_W'(MAXBURST))) begin
          gnt_c      = NREQ'(1) << owner_q;
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end else begin
          rr_ptr_d = owner_nxt;
          if (pick_valid) begin
            gnt_c      = pick;
            owner_d    = pick_idx;
            beat_cnt_d = BEAT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    wdata_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_c[i]) wdata_c = wdata_c | req_data[i*DATASIZE +: DATASIZE];
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign gnt   = wrst ? '0 : gnt_c;
  assign winc  = |gnt;
  assign wdata = wrst ? '0 : wdata_c;
  assign owner = owner_q;
  assign busy  = (state_q == BURST);

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NREQ];
  logic [STAT_W-1:0] stat_d [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      stat_d[i] = stat_q[i];
      if (gnt[i] && req[i] && (stat_q[i] != '1)) stat_d[i] = stat_q[i] + STAT_W'(1);
    end
  end

  always_ff @(posedge wclk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (wrst) stat_q[i] <= '0;
      else      stat_q[i] <= stat_d[i];
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign grant_cnt[g*STAT_W +: STAT_W] = stat_q[g];
  end
`endif

endmodule
